// File: rtl/u_shifter.sv
// 32-bit shift unit for the SimpleRisc execute stage: LSL/LSR/ASR by 0-31
// through a logarithmic barrel shifter, with one registered result stage.
module u_shifter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] m,
   input  logic [SHW-1:0]   n,
   input  logic             is_lsl,
   input  logic             is_lsr,
   input  logic             is_asr,
   output logic [WIDTH-1:0] aluResult,
   output logic             out_valid
);

   logic [WIDTH-1:0]         m_rev;
   logic [WIDTH-1:0]         shifted_rev;
   logic [WIDTH-1:0]         shifted;
   logic [WIDTH-1:0]         result;
   logic [SHW:0][WIDTH-1:0]  stage;
   logic                     fill;

   // Left shifts reuse the right-shift chain by reversing the bits on the way in and out.
   for (genvar i = 0; i < WIDTH; i++) begin : g_rev
      assign m_rev[i]       = m[WIDTH-1-i];
      assign shifted_rev[i] = stage[SHW][WIDTH-1-i];
   end

   assign fill     = is_asr & ~is_lsr & ~is_lsl & m[WIDTH-1];
   assign stage[0] = is_lsl ? m_rev : m;

   for (genvar s = 0; s < SHW; s++) begin : g_stage
      localparam int SH = 1 << s;
      assign stage[s+1] = n[s] ? {{SH{fill}}, stage[s][WIDTH-1:SH]} : stage[s];
   end

   always_comb begin
      shifted = stage[SHW];
      result  = m;
      if (is_lsl) begin
         result = shifted_rev;
      end else if (is_lsr || is_asr) begin
         result = shifted;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aluResult <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            aluResult <= result;
         end
      end
   end

endmodule

// File: tb/tb_u_shifter.sv
// Scoreboard bench for u_shifter: every driven cycle pushes the expected
// out_valid/aluResult, which the monitor pops one cycle later.
module tb_u_shifter;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] m;
   logic [4:0]  n;
   logic        is_lsl;
   logic        is_lsr;
   logic        is_asr;
   logic [31:0] aluResult;
   logic        out_valid;

   typedef struct {
      logic        valid;
      logic [31:0] data;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] heldResult;
   int          compareCount;
   int          mismatchCount;

   u_shifter #(.WIDTH(32), .SHW(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .m         (m),
      .n         (n),
      .is_lsl    (is_lsl),
      .is_lsr    (is_lsr),
      .is_asr    (is_asr),
      .aluResult (aluResult),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] refShift(input logic [31:0] mv, input logic [4:0] nv,
                                            input logic l, input logic r, input logic a);
      if (l)      return mv << nv;
      else if (r) return mv >> nv;
      else if (a) return $unsigned($signed(mv) >>> nv);
      else        return mv;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, records the expected outcome, then waits for the next negedge.
   task automatic applyStimulus(input string tag, input logic rstv, input logic vld,
                                input logic [31:0] mv, input logic [4:0] nv,
                                input logic l, input logic r, input logic a);
      exp_t e;
      rst_n    = rstv;
      in_valid = vld;
      m        = mv;
      n        = nv;
      is_lsl   = l;
      is_lsr   = r;
      is_asr   = a;
      e.tag    = tag;
      if (!rstv) begin
         heldResult = 32'h0;
         e.valid    = 1'b0;
      end else if (vld) begin
         heldResult = refShift(mv, nv, l, r, a);
         e.valid    = 1'b1;
      end else begin
         e.valid    = 1'b0;
      end
      e.data = heldResult;
      sb.push_back(e);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checkOutput({e.tag, "_valid"}, {31'b0, out_valid}, {31'b0, e.valid});
         checkOutput(e.tag, aluResult, e.data);
      end
   end

   initial begin
      logic [1:0] sel;
      compareCount  = 0;
      mismatchCount = 0;
      heldResult    = 32'h0;

      applyStimulus("rst0", 1'b0, 1'b1, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0, 1'b0);
      applyStimulus("rst1", 1'b0, 1'b1, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0, 1'b0);
      applyStimulus("rst_rel", 1'b1, 1'b1, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0, 1'b0);

      applyStimulus("lsl_a", 1'b1, 1'b1, 32'h000000F0, 5'd4, 1'b1, 1'b0, 1'b0);
      applyStimulus("lsl_b", 1'b1, 1'b1, 32'h0000000F, 5'd8, 1'b1, 1'b0, 1'b0);
      applyStimulus("lsr_a", 1'b1, 1'b1, 32'hF0000000, 5'd4, 1'b0, 1'b1, 1'b0);
      applyStimulus("lsr_b", 1'b1, 1'b1, 32'h0F000000, 5'd8, 1'b0, 1'b1, 1'b0);
      applyStimulus("asr_a", 1'b1, 1'b1, 32'hF0000000, 5'd4, 1'b0, 1'b0, 1'b1);
      applyStimulus("asr_b", 1'b1, 1'b1, 32'hFF000000, 5'd8, 1'b0, 1'b0, 1'b1);
      applyStimulus("asr_pos", 1'b1, 1'b1, 32'h70000000, 5'd4, 1'b0, 1'b0, 1'b1);

      applyStimulus("n0_lsl", 1'b1, 1'b1, 32'hA5A5A5A5, 5'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus("n0_lsr", 1'b1, 1'b1, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus("n0_asr", 1'b1, 1'b1, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus("n31_lsl", 1'b1, 1'b1, 32'h80000001, 5'd31, 1'b1, 1'b0, 1'b0);
      applyStimulus("n31_lsr", 1'b1, 1'b1, 32'h80000001, 5'd31, 1'b0, 1'b1, 1'b0);
      applyStimulus("n31_asr", 1'b1, 1'b1, 32'h80000001, 5'd31, 1'b0, 1'b0, 1'b1);

      applyStimulus("prio_lsl_lsr", 1'b1, 1'b1, 32'h00000001, 5'd1, 1'b1, 1'b1, 1'b0);
      applyStimulus("prio_lsr_asr", 1'b1, 1'b1, 32'h80000000, 5'd4, 1'b0, 1'b1, 1'b1);
      applyStimulus("prio_all", 1'b1, 1'b1, 32'h80000001, 5'd3, 1'b1, 1'b1, 1'b1);
      applyStimulus("no_flag", 1'b1, 1'b1, 32'h12345678, 5'd9, 1'b0, 1'b0, 1'b0);

      applyStimulus("idle0", 1'b1, 1'b0, 32'hDEADBEEF, 5'd3, 1'b1, 1'b0, 1'b0);
      applyStimulus("idle1", 1'b1, 1'b0, 32'h00000000, 5'd7, 1'b0, 1'b0, 1'b1);
      applyStimulus("after_idle", 1'b1, 1'b1, 32'h0000FFFF, 5'd16, 1'b1, 1'b0, 1'b0);

      applyStimulus("mid_rst", 1'b0, 1'b1, 32'h0000FFFF, 5'd1, 1'b1, 1'b0, 1'b0);
      applyStimulus("post_rst", 1'b1, 1'b0, 32'h0000FFFF, 5'd1, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         sel = 2'($urandom_range(0, 3));
         applyStimulus($sformatf("rand%0d", i), 1'b1, 1'($urandom_range(0, 4) != 0),
                       $urandom, 5'($urandom_range(0, 31)),
                       sel == 2'd1, sel == 2'd2, sel == 2'd3);
      end

      applyStimulus("drain", 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/u_shifter.md
Name: u_shifter

Overview:
- 32-bit shift unit of the SimpleRisc execute stage. Performs logical shift left, logical shift right or arithmetic shift right by 0–31 positions.
- Operates on operand `m` by shift amount `n`, with the operation selected by one-hot decode flags from the control unit.
- The result is registered, giving one cycle of latency, and is fed to the ALU result mux.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required to be supported.
- SHW, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- in_valid  input  1  operands and flags are valid this cycle.
- m  input  32  operand to be shifted.
- n  input  5  shift amount, unsigned, 0–31.
- is_lsl  input  1  select logical shift left.
- is_lsr  input  1  select logical shift right.
- is_asr  input  1  select arithmetic shift right.
- aluResult  output  32  registered shift result.
- out_valid  output  1  aluResult holds the result of the operands sampled in the previous cycle.

Behaviour:
- Reset: while rst_n=0 at a rising edge, aluResult<=0 and out_valid<=0. Reset overrides in_valid in the same cycle. An operation captured in the cycle reset is asserted is discarded.
- Latency: exactly 1 cycle. Inputs are sampled at edge k and the result appears after edge k with out_valid=1.
- out_valid is a registered copy of in_valid. There is no back-pressure; a new operation may be issued every cycle.
- When in_valid=0 at an edge:
  - out_valid<=0.
  - aluResult holds its previous value.
- Function when in_valid=1:
  - LSL: result = m << n, zero-filled from the LSB.
  - LSR: result = m >> n, zero-filled from the MSB.
  - ASR: result = m >> n, filled with copies of m[31].
- Flag priority when more than one flag is set: is_lsl > is_lsr > is_asr.
- No flag set: result = m unchanged (pass-through). out_valid still follows in_valid.
- n=0: result = m for all three operations.
- n=31:
  - LSL gives {m[0],31'b0}.
  - LSR gives {31'b0,m[31]}.
  - ASR gives 32 copies of m[31].
- Implementation structure:
  - Logarithmic barrel shifter with 5 cascaded stages of 1, 2, 4, 8 and 16 positions, each enabled by the corresponding bit of n.
  - Right shifts use a single shared datapath whose fill bit is (is_asr & ~is_lsr & ~is_lsl) ? m[31] : 0.
  - Left shift is either a separate stage chain or bit-reversal around the right shifter. Both choices are acceptable.
- The shifter path is purely combinational up to the output register. There are no other storage elements.
- No X may propagate to aluResult after reset for any legal input combination.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, m=0xFFFFFFFF, is_lsl=1, n=4 -> aluResult=0x00000000 and out_valid=0. Release reset -> next edge gives aluResult=0xFFFFFFF0, out_valid=1.
- LSL:
  - m=0x000000F0, n=4 -> 0x00000F00.
  - m=0x0000000F, n=8 -> 0x00000F00.
  - Each result appears with out_valid=1 one edge after issue.
- LSR:
  - m=0xF0000000, n=4 -> 0x0F000000.
  - m=0x0F000000, n=8 -> 0x000F0000.
- ASR:
  - m=0xF0000000, n=4 -> 0xFF000000.
  - m=0xFF000000, n=8 -> 0xFFFF0000.
  - m=0x70000000, n=4 -> 0x07000000 (positive operand, zero fill).
- Boundaries:
  - n=0 with each flag, m=0xA5A5A5A5 -> 0xA5A5A5A5.
  - n=31, m=0x80000001: LSL -> 0x80000000, LSR -> 0x00000001, ASR -> 0xFFFFFFFF.
- Control corners:
  - Back-to-back issue on consecutive cycles gives results on consecutive cycles.
  - is_lsl=is_lsr=1, m=0x1, n=1 -> 0x00000002.
  - No flags, m=0x12345678 -> 0x12345678.
  - in_valid=0 -> out_valid=0 and aluResult held.
  - Random sweep of m, n and one-hot flags checked against a reference model.
